// File: rtl/priv_1_13_pipe_ctrl.sv
// rtl/priv_1_13_pipe_ctrl.sv - trap/return fetch redirect sequencer
// Latches a trap or mret, waits for a hazard-free pipe, then strobes insert_pc once with the target.
module priv_1_13_pipe_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0200,
   parameter int          WAIT_LIMIT = 255
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        intr,
   input  logic        mret,
   input  logic        sret,
   input  logic        pipe_clear,
   input  logic [31:0] curr_mtvec,
   input  logic [31:0] curr_mepc,
   input  logic [31:0] next_mcause,
   output logic        insert_pc,
   output logic [31:0] priv_pc,
   output logic        priv_busy,
   output logic        clear_timeout
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_CLEAR = 2'd1,
      INSERT     = 2'd2,
      COOLDOWN   = 2'd3
   } state_t;

   localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

   state_t      state;
   logic        kind_trap;
   logic [31:0] target;
   logic [7:0]  wait_cnt;

   logic [31:0] trap_base;
   logic [31:0] trap_tgt;
   logic [31:0] ret_tgt;
   logic [7:0]  wait_inc;
   logic        preempt;
   logic        unused_inputs;

   // Vectored mode only offsets interrupts; exceptions and reserved modes use the base.
   assign trap_base = {curr_mtvec[31:2], 2'b00};
   assign trap_tgt  = (curr_mtvec[1:0] == 2'b01 && next_mcause[31])
                      ? trap_base + {next_mcause[29:0], 2'b00} : trap_base;
   assign ret_tgt   = {curr_mepc[31:2], 2'b00};
   assign wait_inc  = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;
   assign preempt   = intr && !kind_trap;

   assign unused_inputs = ^{sret, next_mcause[30], curr_mepc[1:0]};

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state         <= IDLE;
         kind_trap     <= 1'b0;
         target        <= 32'h0;
         wait_cnt      <= 8'h0;
         insert_pc     <= 1'b0;
         priv_pc       <= RESET_PC;
         priv_busy     <= 1'b0;
         clear_timeout <= 1'b0;
      end else begin
         insert_pc <= 1'b0;
         case (state)
            IDLE: begin
               if (intr) begin
                  kind_trap <= 1'b1;
                  target    <= trap_tgt;
                  wait_cnt  <= 8'h0;
                  priv_busy <= 1'b1;
                  state     <= WAIT_CLEAR;
               end else if (mret) begin
                  kind_trap <= 1'b0;
                  target    <= ret_tgt;
                  wait_cnt  <= 8'h0;
                  priv_busy <= 1'b1;
                  state     <= WAIT_CLEAR;
               end
            end
            WAIT_CLEAR: begin
               wait_cnt <= wait_inc;
               if (wait_inc == LIMIT) begin
                  clear_timeout <= 1'b1;
               end
               // A trap arriving behind a pending return takes over its slot.
               if (preempt) begin
                  kind_trap <= 1'b1;
                  target    <= trap_tgt;
               end
               if (pipe_clear) begin
                  insert_pc <= 1'b1;
                  priv_pc   <= preempt ? trap_tgt : target;
                  state     <= INSERT;
               end
            end
            INSERT: begin
               state <= COOLDOWN;
            end
            COOLDOWN: begin
               priv_busy <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_priv_1_13_pipe_ctrl.sv
// tb/tb_priv_1_13_pipe_ctrl.sv - self-checking bench for priv_1_13_pipe_ctrl
// Directed scenarios plus random traffic against a request-level reference model.
module tb_priv_1_13_pipe_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0000_0200;
   localparam int          LIMIT    = 4;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        intr, mret, sret, pipe_clear;
   logic [31:0] curr_mtvec, curr_mepc, next_mcause;
   logic        insert_pc;
   logic [31:0] priv_pc;
   logic        priv_busy;
   logic        clear_timeout;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   // model state: pending request, cycles since last strobe, wait count, sticky timeout
   bit          m_pend  = 1'b0;
   bit          m_trap  = 1'b0;
   logic [31:0] m_tgt   = 32'h0;
   int          m_since = 2;
   int          m_wait  = 0;
   bit          m_tmo   = 1'b0;
   bit          e_ins   = 1'b0;
   logic [31:0] e_pc    = RESET_PC;

   priv_1_13_pipe_ctrl #(.RESET_PC(RESET_PC), .WAIT_LIMIT(LIMIT)) dut (
      .CLK(CLK), .nRST(nRST), .intr(intr), .mret(mret), .sret(sret),
      .pipe_clear(pipe_clear), .curr_mtvec(curr_mtvec), .curr_mepc(curr_mepc),
      .next_mcause(next_mcause), .insert_pc(insert_pc), .priv_pc(priv_pc),
      .priv_busy(priv_busy), .clear_timeout(clear_timeout)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic [31:0] trap_pc(input logic [31:0] tvec, input logic [31:0] cause);
      logic [31:0] base;
      base = tvec & 32'hFFFF_FFFC;
      if (tvec[1:0] == 2'd1 && cause[31]) return base + (cause & 32'h3FFF_FFFF) * 4;
      return base;
   endfunction

   always @(posedge CLK or negedge nRST) begin : ref_model
      bit pend, trap, tmo, ins;
      int since, w;
      logic [31:0] tgt, pc;
      if (!nRST) begin
         m_pend <= 1'b0; m_trap <= 1'b0; m_tgt <= 32'h0; m_since <= 2;
         m_wait <= 0; m_tmo <= 1'b0; e_ins <= 1'b0; e_pc <= RESET_PC;
      end else begin
         pend = m_pend; trap = m_trap; tgt = m_tgt; since = m_since;
         w = m_wait; tmo = m_tmo; ins = 1'b0; pc = e_pc;
         if (pend) begin
            w = (w < 255) ? w + 1 : 255;
            if (w == LIMIT) tmo = 1'b1;
            if (intr && !trap) begin
               trap = 1'b1;
               tgt  = trap_pc(curr_mtvec, next_mcause);
            end
            if (pipe_clear) begin
               pend = 1'b0; ins = 1'b1; pc = tgt; since = 0;
            end
         end else if (since < 2) begin
            since = since + 1;
         end else if (intr || mret) begin
            pend = 1'b1;
            trap = intr;
            tgt  = intr ? trap_pc(curr_mtvec, next_mcause) : (curr_mepc & 32'hFFFF_FFFC);
            w    = 0;
         end
         m_pend <= pend; m_trap <= trap; m_tgt <= tgt; m_since <= since;
         m_wait <= w; m_tmo <= tmo; e_ins <= ins; e_pc <= pc;
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         chk("cyc_insert_pc", 32'(insert_pc), 32'(e_ins));
         chk("cyc_priv_pc", priv_pc, e_pc);
         chk("cyc_priv_busy", 32'(priv_busy), 32'(m_pend || m_since < 2));
         chk("cyc_clear_timeout", 32'(clear_timeout), 32'(m_tmo));
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_strobe(input string tag, input logic [31:0] exp_pc, input int exp_lat);
      int lat;
      bit seen;
      lat  = 0;
      seen = 1'b0;
      for (int i = 1; i <= 30 && !seen; i++) begin
         @(negedge CLK);
         if (insert_pc) begin
            seen = 1'b1;
            lat  = i;
         end
      end
      chk({tag, "_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         chk({tag, "_latency"}, lat, exp_lat);
         chk({tag, "_pc"}, priv_pc, exp_pc);
      end
   endtask

   task automatic finish_req(input string tag);
      step();
      intr = 1'b0;
      mret = 1'b0;
      @(negedge CLK);
      chk({tag, "_cooldown_busy"}, 32'(priv_busy), 32'd1);
      chk({tag, "_cooldown_ins"}, 32'(insert_pc), 32'd0);
      @(negedge CLK);
      chk({tag, "_idle_busy"}, 32'(priv_busy), 32'd0);
   endtask

   task automatic no_strobe(input string tag, input int n);
      int c;
      c = 0;
      repeat (n) begin
         @(negedge CLK);
         if (insert_pc) c++;
      end
      chk(tag, c, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ins"}, 32'(insert_pc), 32'd0);
      chk({tag, "_pc"}, priv_pc, RESET_PC);
      chk({tag, "_busy"}, 32'(priv_busy), 32'd0);
      chk({tag, "_tmo"}, 32'(clear_timeout), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      nRST = 1'b0; intr = 1'b0; mret = 1'b0; sret = 1'b0; pipe_clear = 1'b0;
      curr_mtvec = 32'h0; curr_mepc = 32'h0; next_mcause = 32'h0;
      repeat (2) step();
      @(negedge CLK);
      check_reset_outputs("reset");
      step();
      nRST   = 1'b1;
      chk_en = 1'b1;
      repeat (2) step();

      // timeout after 4 WAIT_CLEAR cycles, then reset mid-wait
      mret = 1'b1; curr_mepc = 32'h0000_1236; pipe_clear = 1'b0;
      repeat (5) @(negedge CLK);
      chk("tmo_before", 32'(clear_timeout), 32'd0);
      @(negedge CLK);
      chk("tmo_after", 32'(clear_timeout), 32'd1);
      step();
      mret = 1'b0;
      repeat (2) @(negedge CLK);
      chk("tmo_sticky", 32'(clear_timeout), 32'd1);
      step();
      nRST = 1'b0;
      #2;
      check_reset_outputs("midwait_rst");
      step();
      nRST = 1'b1; pipe_clear = 1'b1;
      no_strobe("rst_no_strobe", 8);

      step();
      curr_mtvec = 32'h8000_0100; next_mcause = 32'h8000_0007; intr = 1'b1;
      wait_strobe("direct", 32'h8000_0100, 3);
      finish_req("direct");

      step();
      curr_mtvec = 32'h8000_0101; next_mcause = 32'h8000_0007; intr = 1'b1;
      wait_strobe("vectored", 32'h8000_011C, 3);
      finish_req("vectored");

      step();
      next_mcause = 32'h0000_0002; intr = 1'b1;
      wait_strobe("vec_exc", 32'h8000_0100, 3);
      finish_req("vec_exc");

      step();
      curr_mepc = 32'h0000_1236; mret = 1'b1;
      wait_strobe("mret", 32'h0000_1234, 3);
      finish_req("mret");

      step();
      curr_mtvec = 32'h8000_0100; next_mcause = 32'h8000_0007; intr = 1'b1; mret = 1'b1;
      wait_strobe("both", 32'h8000_0100, 3);
      finish_req("both");
      no_strobe("both_single", 6);

      // mret stalled, then preempted by a vectored interrupt
      step();
      curr_mtvec = 32'h8000_0101; next_mcause = 32'h8000_0003;
      curr_mepc = 32'h0000_1236; pipe_clear = 1'b0; mret = 1'b1;
      step();
      mret = 1'b0;
      repeat (3) step();
      intr = 1'b1;
      repeat (5) step();
      @(negedge CLK);
      chk("preempt_busy", 32'(priv_busy), 32'd1);
      chk("preempt_ins", 32'(insert_pc), 32'd0);
      step();
      pipe_clear = 1'b1;
      wait_strobe("preempt", 32'h8000_010C, 2);
      finish_req("preempt");

      // intr held through COOLDOWN re-latches only in IDLE
      step();
      curr_mtvec = 32'h8000_0100; next_mcause = 32'h8000_0007; intr = 1'b1;
      wait_strobe("cd_first", 32'h8000_0100, 3);
      wait_strobe("cd_second", 32'h8000_0100, 4);
      finish_req("cd");

      step();
      sret = 1'b1;
      step();
      sret = 1'b0;
      no_strobe("sret_no_strobe", 5);
      chk("sret_busy", 32'(priv_busy), 32'd0);

      for (int i = 0; i < 800; i++) begin
         step();
         nRST        = ($urandom_range(0, 127) != 0);
         intr        = ($urandom_range(0, 3) == 0);
         mret        = ($urandom_range(0, 3) == 0);
         sret        = ($urandom_range(0, 3) == 0);
         pipe_clear  = ($urandom_range(0, 1) == 1);
         curr_mtvec  = $urandom;
         curr_mepc   = $urandom;
         next_mcause = $urandom;
      end
      step();
      nRST = 1'b1; intr = 1'b0; mret = 1'b0; sret = 1'b0; pipe_clear = 1'b1;
      repeat (8) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
